// File: rtl/rmii_frame_tx_if.sv
// Byte-stream port feeding the RMII transmit stage.
// A byte moves on a rising clock edge where valid_in && ready_out; ready_out may depend on valid_in-free state only.
interface rmii_frame_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       last_in;
    logic       ready_out;

    modport master (
        output data_in,
        output valid_in,
        output last_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  last_in,
        output ready_out
    );
endinterface

// File: rtl/rmii_frame_tx.sv
// Ethernet MAC transmit stage: frames a byte stream with preamble, SFD, pad and CRC-32 FCS
// and serialises it onto RMII, one dibit per 50 MHz cycle, followed by the inter-frame gap.
module rmii_frame_tx #(
    parameter int PAD_MIN   = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic           clk_in,
    input  logic           rst_in,
    rmii_frame_tx_if.slave s_if,
    output logic           eth_txen,
    output logic [1:0]     eth_txd,
    output logic           busy_out,
    output logic           underrun_out,
    output logic [2:0]     state_dbg_out
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] PAD_LEN  = 11'(PAD_MIN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [10:0] bcnt_q, bcnt_d;
    logic [31:0] crc_q, crc_d;
    logic        txen_q, txen_d;
    logic [1:0]  txd_q, txd_d;
    logic        busy_q;
    logic        ready_c, underrun_c, phase_end;
    logic [10:0] bcnt_inc;
    logic [31:0] fcs_w;

    // Reflected CRC-32 advanced by one dibit, bit 0 being first on the wire.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            bcnt_q  <= '0;
            crc_q   <= '0;
            txen_q  <= 1'b0;
            txd_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            crc_q   <= crc_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        byte_d     = byte_q;
        last_d     = last_q;
        bcnt_d     = bcnt_q;
        crc_d      = crc_q;
        ready_c    = 1'b0;
        underrun_c = 1'b0;
        txen_d     = 1'b1;
        txd_d      = 2'b00;
        fcs_w      = 32'h0;
        phase_end  = (cnt_q[1:0] == 2'd3);
        bcnt_inc   = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (s_if.valid_in) state_d = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (cnt_q == 16'd27) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end
            end
            S_SFD: begin
                crc_d  = 32'hFFFF_FFFF;
                bcnt_d = '0;
                if (phase_end) begin
                    ready_c = 1'b1;
                    cnt_d   = '0;
                    if (s_if.valid_in) begin
                        state_d = S_DATA;
                        byte_d  = s_if.data_in;
                        last_d  = s_if.last_in;
                    end else begin
                        underrun_c = 1'b1;
                        state_d    = S_IFG;
                    end
                end
            end
            S_DATA, S_PAD: begin
                crc_d = crc_dibit(crc_q, txd_q);
                if (phase_end) begin
                    bcnt_d = bcnt_inc;
                    cnt_d  = '0;
                    if (state_q == S_DATA && !last_q) begin
                        ready_c = 1'b1;
                        if (s_if.valid_in) begin
                            byte_d = s_if.data_in;
                            last_d = s_if.last_in;
                        end else begin
                            underrun_c = 1'b1;
                            state_d    = S_IFG;
                        end
                    end else if (bcnt_inc < PAD_LEN) begin
                        state_d = S_PAD;
                        byte_d  = 8'h00;
                    end else begin
                        state_d = S_FCS;
                    end
                end
            end
            S_FCS: begin
                if (cnt_q == 16'd15) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                // A request already waiting skips IDLE so the gap stays exactly IFG long.
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = s_if.valid_in ? S_PREAMBLE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Wire outputs are registered, so they are derived from the next state.
        fcs_w = ~crc_d;
        case (state_d)
            S_PREAMBLE:   txd_d = 2'b01;
            S_SFD:        txd_d = (cnt_d[1:0] == 2'd3) ? 2'b11 : 2'b01;
            S_DATA, S_PAD: txd_d = byte_d[{cnt_d[1:0], 1'b0} +: 2];
            S_FCS:        txd_d = fcs_w[{cnt_d[3:0], 1'b0} +: 2];
            default:      txen_d = 1'b0;
        endcase
    end

    assign s_if.ready_out = ready_c;
    assign underrun_out   = underrun_c;
    assign eth_txen       = txen_q;
    assign eth_txd        = txd_q;
    assign busy_out       = busy_q;
    assign state_dbg_out  = state_q;
endmodule

// File: tb/tb_rmii_frame_tx.sv
// Bench for rmii_frame_tx: one instance without padding, one with the default 60-byte pad;
// a wire monitor deserialises each frame and checks it against the expected-byte queue.
module tb_rmii_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       sel = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_valid = 1'b0;
    logic       drv_last = 1'b0;

    rmii_frame_tx_if if_a ();
    rmii_frame_tx_if if_b ();

    assign if_a.data_in  = drv_data;
    assign if_a.last_in  = drv_last;
    assign if_a.valid_in = drv_valid & ~sel;
    assign if_b.data_in  = drv_data;
    assign if_b.last_in  = drv_last;
    assign if_b.valid_in = drv_valid & sel;

    logic       txen_a, busy_a, und_a, txen_b, busy_b, und_b;
    logic [1:0] txd_a, txd_b;
    logic [2:0] st_a, st_b;

    rmii_frame_tx #(.PAD_MIN(0), .IFG_BYTES(12)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .s_if(if_a),
        .eth_txen(txen_a), .eth_txd(txd_a), .busy_out(busy_a),
        .underrun_out(und_a), .state_dbg_out(st_a)
    );

    rmii_frame_tx #(.PAD_MIN(60), .IFG_BYTES(12)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .s_if(if_b),
        .eth_txen(txen_b), .eth_txd(txd_b), .busy_out(busy_b),
        .underrun_out(und_b), .state_dbg_out(st_b)
    );

    wire       txen_m  = sel ? txen_b : txen_a;
    wire [1:0] txd_m   = sel ? txd_b : txd_a;
    wire       ready_m = sel ? if_b.ready_out : if_a.ready_out;
    wire       busy_m  = sel ? busy_b : busy_a;
    wire       und_m   = sel ? und_b : und_a;

    int vectors = 0;
    int fails   = 0;

    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    logic [7:0] fr[0:127];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc32_model(input int n, input int tot);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < tot; i++) begin
            b = (i < n) ? fr[i] : 8'h00;
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_expect(input int n, input int pad_min, input bit fixed_fcs,
                               input logic [31:0] fcs_val);
        int tot;
        logic [31:0] f;
        tot = (n < pad_min) ? pad_min : n;
        for (int i = 0; i < tot; i++) exp_q.push_back((i < n) ? fr[i] : 8'h00);
        f = fixed_fcs ? fcs_val : crc32_model(n, tot);
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
        exp_len_q.push_back(32 + 4 * tot + 16);
    endtask

    task automatic push_trunc(input int nbytes, input int len);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(fr[i]);
        exp_len_q.push_back(len);
    endtask

    // Wire monitor: captures dibits while txen is high and checks the frame when it drops.
    logic [1:0] cap[$];
    int frames = 0, rise_cyc = 0, fall_cyc = 0, last_gap = 0, rdy_cnt = 0;

    task automatic check_frame();
        int exp_len, nb;
        logic [7:0] got, want;
        logic [1:0] pre;
        bit pre_ok;
        if (exp_len_q.size() == 0) begin
            chk("unexpected_frame", 32'(cap.size()), 32'h0);
            return;
        end
        exp_len = exp_len_q.pop_front();
        chk("frame_len", 32'(cap.size()), 32'(exp_len));
        pre_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pre = (i == 31) ? 2'b11 : 2'b01;
            if (i >= cap.size() || cap[i] !== pre) pre_ok = 1'b0;
        end
        chk("preamble_sfd", 32'(pre_ok), 32'h1);
        nb = (exp_len - 32) / 4;
        for (int b = 0; b < nb; b++) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            got  = 8'hxx;
            if (32 + 4 * b + 3 < cap.size())
                got = {cap[32+4*b+3], cap[32+4*b+2], cap[32+4*b+1], cap[32+4*b]};
            chk($sformatf("frame%0d_byte%0d", frames, b), 32'(got), 32'(want));
        end
    endtask

    always @(negedge clk) begin
        if (ready_m) rdy_cnt++;
        if (txen_m) begin
            if (cap.size() == 0) begin
                rise_cyc = cyc;
                last_gap = cyc - fall_cyc;
            end
            cap.push_back(txd_m);
        end else if (cap.size() > 0) begin
            fall_cyc = cyc;
            check_frame();
            cap.delete();
            frames++;
        end
    end

    int t_valid = 0;
    int first_rdy = -1;

    task automatic send_frame(input int n, input bit hold, input int cut, input bit do_rst);
        int i, guard;
        @(posedge clk); #1;
        t_valid   = cyc;
        first_rdy = -1;
        i         = 0;
        guard     = 0;
        drv_data  = fr[0];
        drv_last  = (n == 1);
        drv_valid = 1'b1;
        while (i < n) begin
            @(negedge clk);
            guard++;
            if (guard > 4000) begin
                chk("send_timeout", 32'(i), 32'(n));
                drv_valid = 1'b0;
                break;
            end
            if (ready_m) begin
                if (first_rdy < 0) first_rdy = cyc;
                @(posedge clk); #1;
                i++;
                if (i == cut) begin
                    drv_valid = 1'b0;
                    if (do_rst) begin
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                    end
                    break;
                end
                if (i < n) begin
                    drv_data = fr[i];
                    drv_last = (i == n - 1);
                end else begin
                    drv_valid = hold;
                end
            end
        end
    endtask

    task automatic wait_frames(input int target);
        int guard;
        guard = 0;
        while (frames < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("frames_seen", 32'(frames), 32'(target));
    endtask

    int r0, u, g;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txen", 32'({txen_a, txen_b}), 32'h0);
        chk("rst_txd", 32'({txd_a, txd_b}), 32'h0);
        chk("rst_ready", 32'({if_a.ready_out, if_b.ready_out}), 32'h0);
        chk("rst_busy", 32'({busy_a, busy_b}), 32'h0);
        chk("rst_underrun", 32'({und_a, und_b}), 32'h0);
        chk("rst_state", 32'({st_a, st_b}), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // "123456789" without padding; FCS bytes are the well-known CRC-32 check value.
        sel = 1'b0;
        for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
        push_expect(9, 0, 1'b1, 32'hCBF43926);
        send_frame(9, 1'b0, -1, 1'b0);
        wait_frames(1);

        // Single byte padded to 60, with preamble timing and single ready pulse.
        sel = 1'b1;
        repeat (2) @(posedge clk);
        fr[0] = 8'hAB;
        push_expect(1, 60, 1'b0, 32'h0);
        r0 = rdy_cnt;
        send_frame(1, 1'b0, -1, 1'b0);
        wait_frames(2);
        chk("txen_rise_latency", 32'(rise_cyc - t_valid), 32'd1);
        chk("first_ready_latency", 32'(first_rdy - t_valid), 32'd32);
        chk("single_byte_ready_pulses", 32'(rdy_cnt - r0), 32'd1);

        // Back-to-back 64-byte frames with valid held across the gap.
        for (int i = 0; i < 64; i++) fr[i] = 8'(7 * i + 3);
        push_expect(64, 60, 1'b0, 32'h0);
        send_frame(64, 1'b1, -1, 1'b0);
        for (int i = 0; i < 64; i++) fr[i] = 8'(255 - 3 * i);
        push_expect(64, 60, 1'b0, 32'h0);
        send_frame(64, 1'b0, -1, 1'b0);
        wait_frames(4);
        chk("b2b_gap", 32'(last_gap), 32'd48);

        // Underrun after nine bytes; the frame is truncated with no FCS.
        for (int i = 0; i < 64; i++) fr[i] = 8'(i ^ 8'h5A);
        push_trunc(9, 68);
        send_frame(64, 1'b0, 9, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!ready_m && g < 20);
        chk("underrun_pulse", 32'(und_m), 32'h1);
        u = cyc;
        @(negedge clk);
        chk("underrun_txen_drop", 32'(txen_m), 32'h0);
        chk("underrun_one_cycle", 32'(und_m), 32'h0);
        g = 0;
        while (busy_m && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("underrun_busy_release", 32'(cyc - (u + 1)), 32'd48);
        for (int i = 0; i < 20; i++) fr[i] = 8'(8'hC0 + i);
        push_expect(20, 60, 1'b0, 32'h0);
        send_frame(20, 1'b0, -1, 1'b0);
        wait_frames(6);

        // Reset during DATA, then a normal unpadded-length frame.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 30; i++) fr[i] = 8'(8'h11 * i);
        push_trunc(4, 49);
        send_frame(30, 1'b0, 5, 1'b1);
        @(negedge clk);
        chk("midreset_txen", 32'(txen_m), 32'h0);
        chk("midreset_ready", 32'(ready_m), 32'h0);
        chk("midreset_busy", 32'(busy_m), 32'h0);
        for (int i = 0; i < 61; i++) fr[i] = 8'(i * i + 1);
        push_expect(61, 60, 1'b0, 32'h0);
        send_frame(61, 1'b0, -1, 1'b0);
        wait_frames(8);

        chk("exp_bytes_left", 32'(exp_q.size()), 32'h0);
        chk("exp_frames_left", 32'(exp_len_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
